// File: rtl/axis_s_pkt_rx_if.sv
// -----------------------------------------------------------------------------
// axis_s_pkt_rx_if
// AXI4-Stream bundle carried between the team's axis_m master and the
// axis_s_pkt_rx receiver.
//
// Signals:
//   tdata   [DATA_W]  stream data          (master -> slave)
//   tvalid            beat is valid        (master -> slave)
//   tlast             last beat of packet  (master -> slave)
//   tready            slave accepts beat   (slave  -> master)
// -----------------------------------------------------------------------------
interface axis_s_pkt_rx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tlast;
    logic              tready;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/axis_s_pkt_rx.sv
// -----------------------------------------------------------------------------
// axis_s_pkt_rx
// AXI4-Stream receiver. Accepted beats are stored with their tlast flag in a
// DEPTH-entry FIFO that a consumer drains through a registered read port.
// A two-state packet tracker counts beats per packet, pulses pkt_done when a
// tlast beat is accepted and flags packets that reach MAX_BEATS without tlast.
//
// Ports:
//   s_axis_aclk     in   clock, rising edge
//   s_axis_areset   in   asynchronous active-high reset
//   s_axis          slave modport of axis_s_pkt_rx_if (tdata/tvalid/tlast/tready)
//   rd_en           in   pop one beat from the FIFO
//   dout            out  popped data (registered, 1-cycle latency)
//   dout_last       out  tlast flag of the popped beat
//   empty / full    out  FIFO holds 0 / DEPTH beats (registered)
//   count           out  FIFO occupancy
//   pkt_done        out  one-cycle pulse after a tlast beat is accepted
//   pkt_len         out  beat count of the last completed packet
//   pkt_cnt         out  completed packets, wraps 255 -> 0
//   len_err         out  sticky: a packet reached MAX_BEATS without tlast
// -----------------------------------------------------------------------------
module axis_s_pkt_rx #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int MAX_BEATS = 255
) (
    input  logic                     s_axis_aclk,
    input  logic                     s_axis_areset,
    axis_s_pkt_rx_if.slave           s_axis,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        dout,
    output logic                     dout_last,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     pkt_done,
    output logic [7:0]               pkt_len,
    output logic [7:0]               pkt_cnt,
    output logic                     len_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, RX} state_t;

    // Each entry is {tlast, tdata}.
    logic [DATA_W:0]  mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_next;
    logic             accept;
    logic             pop;

    state_t           state, state_next;
    logic [7:0]       beat_cnt, beat_cnt_next;
    logic [7:0]       beats_now;
    logic             pkt_end;
    logic             err_hit;

    assign accept = s_axis.tvalid & s_axis.tready;
    assign pop    = rd_en & ~empty;

    // NOTE: always_comb outputs get a default first so no branch leaves one
    // unassigned; that is what keeps latches from being inferred.
    always_comb begin
        count_next = count;
        case ({accept, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // NOTE: storage has no reset; contents are only meaningful behind the
    // pointers, and a resettable array would cost a reset net per bit.
    always_ff @(posedge s_axis_aclk) begin
        if (accept) begin
            mem[wr_ptr] <= {s_axis.tlast, s_axis.tdata};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // in the block samples pre-edge values regardless of statement order.
    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            empty         <= 1'b1;
            full          <= 1'b0;
            s_axis.tready <= 1'b0;
            dout          <= '0;
            dout_last     <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + AW'(1);
                dout      <= mem[rd_ptr][DATA_W-1:0];
                dout_last <= mem[rd_ptr][DATA_W];
            end
            count         <= count_next;
            empty         <= (count_next == CW'(0));
            full          <= (count_next == CW'(DEPTH));
            // Registered ready looks at next occupancy, so it is low in the
            // same cycle the FIFO becomes full and no overflow is possible.
            s_axis.tready <= (count_next != CW'(DEPTH));
        end
    end

    // Packet tracker: state register.
    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            state    <= IDLE;
            beat_cnt <= '0;
        end else begin
            state    <= state_next;
            beat_cnt <= beat_cnt_next;
        end
    end

    // Packet tracker: next state. beats_now is the length of the current
    // packet including the beat being accepted this cycle.
    always_comb begin
        state_next    = state;
        beat_cnt_next = beat_cnt;
        pkt_end       = 1'b0;
        err_hit       = 1'b0;
        beats_now     = (state == IDLE) ? 8'd1 : beat_cnt + 8'd1;
        if (accept) begin
            if (s_axis.tlast) begin
                pkt_end       = 1'b1;
                state_next    = IDLE;
                beat_cnt_next = '0;
            end else if (beats_now == 8'(MAX_BEATS)) begin
                // Over-long packet: flag it and treat what follows as a
                // fresh packet.
                err_hit       = 1'b1;
                state_next    = IDLE;
                beat_cnt_next = '0;
            end else begin
                state_next    = RX;
                beat_cnt_next = beats_now;
            end
        end
    end

    // Packet statistics.
    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            pkt_done <= 1'b0;
            pkt_len  <= '0;
            pkt_cnt  <= '0;
            len_err  <= 1'b0;
        end else begin
            pkt_done <= pkt_end;
            if (pkt_end) begin
                pkt_len <= beats_now;
                pkt_cnt <= pkt_cnt + 8'd1;
            end
            if (err_hit) begin
                len_err <= 1'b1;
            end
        end
    end
endmodule
